// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Brief    : Shared types and constants for the branch resolve queue.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Default number of in-flight predicted branches
  localparam int DEFAULT_DEPTH = 8;

  // Fall-through increment for a not-taken branch
  localparam logic [31:0] PC_INC = 32'd4;

  // One predicted-branch record as captured at fetch
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_rec_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pred_fifo
//  Brief    : Circular buffer of prediction records with a synchronous flush.
//             Full/empty are derived from the occupancy counter, and pointers
//             wrap naturally because DEPTH is a power of two.
//  Revision : 1.0 - initial release
// ============================================================================
module pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  pred_rec_t                push_data,
  input  logic                     pop,
  input  logic                     flush,
  output pred_rec_t                head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW      = $clog2(DEPTH);
  localparam logic [PW:0]    C_DEPTH = (PW+1)'(DEPTH);

  pred_rec_t         r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW:0]       r_count;

  logic              w_do_push;
  logic              w_do_pop;

  // Requests against a full/empty buffer are ignored here as well, so the
  // buffer is self-protecting regardless of the caller.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign full      = (r_count == C_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_head];

  // Pointer and occupancy bookkeeping; flush wins over a same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record storage; contents are don't-care after reset or flush
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_tail] <= push_data;
  end

endmodule : pred_fifo
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_queue
//  Brief    : Holds outstanding branch predictions in order, compares each
//             against its execute-stage outcome, trains the BHT, redirects
//             fetch on a mispredict (flushing younger entries) and counts
//             mispredicts with saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_target,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_taken,
  input  logic [31:0]              ex_target,
  output logic                     resolve_valid,
  output logic [31:0]              resolve_pc,
  output logic                     resolve_taken,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [CNTW-1:0]          mispredict_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  pred_rec_t         w_push_rec;
  pred_rec_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_mispredict;
  logic              w_flush;
  logic [31:0]       w_redirect_pc;

  assign pred_ready = !w_full;
  assign ex_ready   = !w_empty;

  assign w_push = pred_valid && pred_ready;
  assign w_pop  = ex_valid && ex_ready;

  assign w_push_rec = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  // Target only matters when the branch was actually taken
  assign w_mispredict  = (w_head.taken != ex_taken) ||
                         (ex_taken && (w_head.target != ex_target));
  assign w_flush       = w_pop && w_mispredict;
  assign w_redirect_pc = ex_taken ? ex_target : (w_head.pc + PC_INC);

  pred_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_rec),
    .pop       (w_pop),
    .flush     (w_flush),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (occupancy)
  );

  // Registered BHT-training and redirect outputs; data holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_valid  <= 1'b0;
      resolve_pc     <= '0;
      resolve_taken  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      resolve_valid  <= w_pop;
      redirect_valid <= w_flush;
      if (w_pop) begin
        resolve_pc    <= w_head.pc;
        resolve_taken <= ex_taken;
      end
      if (w_flush) redirect_pc <= w_redirect_pc;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_count <= '0;
    end else if (w_flush && (mispredict_count != '1)) begin
      mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule : branch_resolve_queue
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_queue
//  Brief    : Randomised scoreboard bench for branch_resolve_queue. A queue
//             model of outstanding predictions produces expected responses;
//             a negedge monitor pops and compares them.
//             The counter width is narrowed so saturation is reachable
//             within a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int CNTW  = 6;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk;
  logic            rst_n;
  logic            pred_valid;
  logic            pred_ready;
  logic [31:0]     pred_pc;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_taken;
  logic [31:0]     ex_target;
  logic            resolve_valid;
  logic [31:0]     resolve_pc;
  logic            resolve_taken;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [CNTW-1:0] mispredict_count;
  logic [OW-1:0]   occupancy;

  branch_resolve_queue #(
    .DEPTH            (DEPTH),
    .CNTW             (CNTW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_valid       (pred_valid),
    .pred_ready       (pred_ready),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .resolve_taken    (resolve_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count),
    .occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic taken; logic [31:0] tgt; } rec_t;
  typedef struct { int occ; bit pr; bit er; int cnt; bit rv; bit dv; } st_t;
  typedef struct { logic [31:0] pc; logic taken; } res_t;

  rec_t        model[$];
  st_t         st_q[$];
  res_t        res_q[$];
  logic [31:0] red_q[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  bit          prev_pop = 1'b0;
  bit          prev_mis = 1'b0;
  int          exp_cnt  = 0;
  logic [31:0] last_res_pc = '0;
  logic [31:0] last_red_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus: record the expected visible state for this cycle,
  // apply the queue rules to the model, then advance past the edge.
  task automatic cycle(input bit pv, input logic [31:0] ppc, input bit pt,
                       input logic [31:0] ptg, input bit ev, input bit et,
                       input logic [31:0] etg);
    st_t  s;
    rec_t h;
    rec_t n;
    res_t r;
    bit   push_ok, pop_ok, mis;
    pred_valid  = pv;  pred_pc  = ppc; pred_taken = pt; pred_target = ptg;
    ex_valid    = ev;  ex_taken = et;  ex_target  = etg;
    s.occ = model.size(); s.pr = (model.size() < DEPTH); s.er = (model.size() > 0);
    s.cnt = exp_cnt; s.rv = prev_pop; s.dv = prev_mis;
    st_q.push_back(s);
    push_ok = pv && (model.size() < DEPTH);
    pop_ok  = ev && (model.size() > 0);
    mis     = 1'b0;
    if (pop_ok) begin
      h = model.pop_front();
      mis = (h.taken != et) || (et && (h.tgt != etg));
      r.pc = h.pc; r.taken = et;
      res_q.push_back(r);
      if (mis) begin
        red_q.push_back(et ? etg : h.pc + 32'd4);
        model.delete();
        if (exp_cnt < CMAX) exp_cnt++;
      end
    end
    if (push_ok && !mis) begin
      n.pc = ppc; n.taken = pt; n.tgt = ptg;
      model.push_back(n);
    end
    prev_pop = pop_ok;
    prev_mis = mis;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Execute outcome that agrees with the current oldest prediction
  task automatic correct_pop(input bit pv, input logic [31:0] ppc, input bit pt,
                             input logic [31:0] ptg);
    logic       et;
    logic [31:0] etg;
    et  = (model.size() > 0) ? model[0].taken : 1'b0;
    etg = (model.size() > 0) ? model[0].tgt   : 32'h0;
    cycle(pv, ppc, pt, ptg, 1'b1, et, etg);
  endtask

  // Scoreboard monitor: compares expected per-cycle state and pops expected
  // responses whenever the DUT presents a resolve or redirect.
  st_t  ms;
  res_t mr;
  always @(negedge clk) begin
    if (mon_en && st_q.size() > 0) begin
      ms = st_q.pop_front();
      check("occupancy",        32'(occupancy),        32'(ms.occ));
      check("pred_ready",       32'(pred_ready),       32'(ms.pr));
      check("ex_ready",         32'(ex_ready),         32'(ms.er));
      check("mispredict_count", 32'(mispredict_count), 32'(ms.cnt));
      check("resolve_valid",    32'(resolve_valid),    32'(ms.rv));
      check("redirect_valid",   32'(redirect_valid),   32'(ms.dv));
      if (resolve_valid) begin
        if (res_q.size() == 0) begin
          n_checks++;
          $display("FAIL resolve_unexpected: got pc 0x%0h expected no resolve", resolve_pc);
        end else begin
          mr = res_q.pop_front();
          check("resolve_pc",    resolve_pc,          mr.pc);
          check("resolve_taken", 32'(resolve_taken),  32'(mr.taken));
          last_res_pc = mr.pc;
        end
      end else begin
        check("resolve_pc_hold", resolve_pc, last_res_pc);
      end
      if (redirect_valid) begin
        if (red_q.size() == 0) begin
          n_checks++;
          $display("FAIL redirect_unexpected: got pc 0x%0h expected no redirect", redirect_pc);
        end else begin
          last_red_pc = red_q.pop_front();
          check("redirect_pc", redirect_pc, last_red_pc);
        end
      end else begin
        check("redirect_pc_hold", redirect_pc, last_red_pc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_ready",  32'(pred_ready),       32'd1);
    check("rst_ex_ready",    32'(ex_ready),         32'd0);
    check("rst_occupancy",   32'(occupancy),        32'd0);
    check("rst_resolve_v",   32'(resolve_valid),    32'd0);
    check("rst_resolve_pc",  resolve_pc,            32'd0);
    check("rst_resolve_t",   32'(resolve_taken),    32'd0);
    check("rst_redirect_v",  32'(redirect_valid),   32'd0);
    check("rst_redirect_pc", redirect_pc,           32'd0);
    check("rst_count",       32'(mispredict_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Correct taken prediction
    cycle(1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
    cycle(0, 32'h0,   0, 32'h0,   1, 1, 32'h200);
    idle();
    // Predicted not-taken, actually taken
    cycle(1, 32'h104, 0, 32'h0,   0, 0, 32'h0);
    cycle(0, 32'h0,   0, 32'h0,   1, 1, 32'h300);
    idle();
    // Predicted taken, actually not-taken, with a same-cycle push discarded
    cycle(1, 32'h108, 1, 32'h400, 0, 0, 32'h0);
    cycle(1, 32'h500, 1, 32'h600, 1, 0, 32'h0);
    idle(); idle();
    // Fill, then pop+push while full, then drain
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h1000 + 32'(4*i), 0, 32'h0, 0, 0, 32'h0);
    cycle(1, 32'h2000, 0, 32'h0, 1, 0, 32'h0);
    idle();
    for (int i = 0; i < DEPTH; i++) correct_pop(0, 32'h0, 0, 32'h0);
    idle();
    // Streaming push/pop across pointer wrap
    cycle(1, 32'h3000, 1, 32'h3100, 0, 0, 32'h0);
    for (int i = 1; i <= 20; i++) correct_pop(1, 32'h3000 + 32'(4*i), i[0], 32'h3100 + 32'(i));
    correct_pop(0, 32'h0, 0, 32'h0);
    idle();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      bit          pv, pt, ev, et;
      logic [31:0] ppc, ptg, etg;
      pv  = ($urandom_range(0, 3) != 0);
      ev  = ($urandom_range(0, 2) != 0);
      ppc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 31) == 0) ppc = 32'hFFFF_FFFC;
      pt  = $urandom_range(0, 1);
      ptg = $urandom & 32'h0000_00FC;
      if (model.size() > 0 && $urandom_range(0, 7) != 0) begin
        et = model[0].taken; etg = model[0].tgt;
      end else begin
        et = $urandom_range(0, 1); etg = $urandom & 32'h0000_00FC;
      end
      cycle(pv, ppc, pt, ptg, ev, et, etg);
    end
    idle();

    // Reset with three entries and a mispredicting pop presented
    for (int i = 0; i < 3; i++) cycle(1, 32'h4000 + 32'(4*i), 1, 32'h10, 0, 0, 32'h0);
    mon_en = 1'b0;
    ex_valid = 1'b1; ex_taken = 1'b0; ex_target = '0; pred_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_occupancy",  32'(occupancy),        32'd0);
    check("midrst_ex_ready",   32'(ex_ready),         32'd0);
    check("midrst_pred_ready", 32'(pred_ready),       32'd1);
    check("midrst_count",      32'(mispredict_count), 32'd0);
    check("midrst_redirect_v", 32'(redirect_valid),   32'd0);
    @(posedge clk); #1;
    check("midrst_redirect_v2", 32'(redirect_valid),  32'd0);
    check("midrst_resolve_v2",  32'(resolve_valid),   32'd0);
    check("midrst_redirect_pc", redirect_pc,          32'd0);
    ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model.delete(); res_q.delete(); red_q.delete(); st_q.delete();
    exp_cnt = 0; prev_pop = 1'b0; prev_mis = 1'b0;
    last_res_pc = '0; last_red_pc = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Drive the counter into saturation
    for (int i = 0; i < CMAX + 6; i++) begin
      cycle(1, 32'h5000 + 32'(4*i), 1, 32'h40, 0, 0, 32'h0);
      cycle(0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
    end
    idle(); idle();

    mon_en = 1'b0;
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    check("red_q_drained", 32'(red_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_branch_resolve_queue
`default_nettype wire
